// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port SPI read arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W     = 24;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned NB_W       = 3;
  localparam int unsigned MEM_NB_W   = 4;
  localparam int unsigned NBYTES_MIN = 1;
  localparam int unsigned NBYTES_MAX = 4;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RELEASE
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [NB_W-1:0]   nbytes;
  } rd_req_t;

  function automatic logic nbytes_legal(input logic [NB_W-1:0] nb);
    return (nb >= NB_W'(NBYTES_MIN)) && (nb <= NB_W'(NBYTES_MAX));
  endfunction

endpackage

// File: rtl/mem_byte_order.sv
// Reorders the engine's MSB-first byte stream into a little-endian word;
// lanes at or above nbytes are zero.
module mem_byte_order
  import mem_arb_pkg::*;
(
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic [NB_W-1:0]   nbytes_i,
  output logic [DATA_W-1:0] rdata_c_o
);

  localparam int unsigned LANES = DATA_W / 8;

  // Byte k of the result came in as the (n-1-k)-th lowest byte of mem_rdata.
  always_comb begin
    rdata_c_o = '0;
    if (nbytes_i <= NB_W'(NBYTES_MAX)) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        for (int unsigned j = 0; j < LANES; j++) begin
          if (32'(nbytes_i) == k + j + 1) begin
            rdata_c_o[8*k +: 8] = mem_rdata_i[8*j +: 8];
          end
        end
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one SPI read engine between fetch (i) and
// load (d) ports, with a per-transaction watchdog.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned TMO_W          = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [NB_W-1:0]     i_nbytes,
  output logic                i_ack,
  output logic                i_err,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [NB_W-1:0]     d_nbytes,
  output logic                d_ack,
  output logic                d_err,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_start,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [MEM_NB_W-1:0] mem_nbytes,
  input  logic                mem_done,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  state_e              state_q, state_d;
  logic                last_q, last_d;
  logic                grant_q, grant_d;
  logic [TMO_W-1:0]    wdog_q, wdog_d;
  logic                mem_start_q, mem_start_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [MEM_NB_W-1:0] mem_nbytes_q, mem_nbytes_d;
  logic                i_ack_q, i_ack_d, d_ack_q, d_ack_d;
  logic                i_err_q, i_err_d, d_err_q, d_err_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;

  rd_req_t             i_bus, d_bus, sel;
  logic                fin, fin_err;
  logic [DATA_W-1:0]   fin_data;
  logic [DATA_W-1:0]   swapped;

  assign i_bus = '{addr: i_addr, nbytes: i_nbytes};
  assign d_bus = '{addr: d_addr, nbytes: d_nbytes};

  mem_byte_order u_byte_order (
    .mem_rdata_i (mem_rdata),
    .nbytes_i    (mem_nbytes_q[NB_W-1:0]),
    .rdata_c_o   (swapped)
  );

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    grant_d      = grant_q;
    wdog_d       = wdog_q;
    mem_start_d  = mem_start_q;
    mem_addr_d   = mem_addr_q;
    mem_nbytes_d = mem_nbytes_q;
    i_ack_d      = 1'b0;
    d_ack_d      = 1'b0;
    i_err_d      = i_err_q;
    d_err_d      = d_err_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    sel          = i_bus;
    fin          = 1'b0;
    fin_err      = 1'b0;
    fin_data     = '0;

    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          if (i_req && d_req) grant_d = ~last_q;
          else                grant_d = d_req ? PORT_D : PORT_I;
          sel          = (grant_d == PORT_D) ? d_bus : i_bus;
          last_d       = grant_d;
          wdog_d       = '0;
          mem_addr_d   = sel.addr;
          mem_nbytes_d = MEM_NB_W'(sel.nbytes);
          if (nbytes_legal(sel.nbytes)) begin
            state_d     = ISSUE;
            mem_start_d = 1'b1;
          end else begin
            // Illegal length: answer with an error without touching the engine.
            state_d = RELEASE;
            fin     = 1'b1;
            fin_err = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (mem_done) begin
          fin         = 1'b1;
          fin_data    = swapped;
          mem_start_d = 1'b0;
          state_d     = RELEASE;
        end else if (wdog_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          fin         = 1'b1;
          fin_err     = 1'b1;
          mem_start_d = 1'b0;
          state_d     = RELEASE;
        end else begin
          wdog_d = wdog_q + TMO_W'(1);
        end
      end
      RELEASE: begin
        // Requests ignored here so mem_start stays low long enough to re-arm the engine.
        mem_start_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (fin) begin
      if (grant_d == PORT_I) begin
        i_ack_d   = 1'b1;
        i_err_d   = fin_err;
        i_rdata_d = fin_data;
      end else begin
        d_ack_d   = 1'b1;
        d_err_d   = fin_err;
        d_rdata_d = fin_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_q       <= PORT_D;
      grant_q      <= PORT_I;
      wdog_q       <= '0;
      mem_start_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_nbytes_q <= '0;
      i_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      i_err_q      <= 1'b0;
      d_err_q      <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      grant_q      <= grant_d;
      wdog_q       <= wdog_d;
      mem_start_q  <= mem_start_d;
      mem_addr_q   <= mem_addr_d;
      mem_nbytes_q <= mem_nbytes_d;
      i_ack_q      <= i_ack_d;
      d_ack_q      <= d_ack_d;
      i_err_q      <= i_err_d;
      d_err_q      <= d_err_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign mem_start  = mem_start_q;
  assign mem_addr   = mem_addr_q;
  assign mem_nbytes = mem_nbytes_q;
  assign i_ack      = i_ack_q;
  assign i_err      = i_err_q;
  assign i_rdata    = i_rdata_q;
  assign d_ack      = d_ack_q;
  assign d_err      = d_err_q;
  assign d_rdata    = d_rdata_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single SPI serial-memory read engine between two requesters: instruction fetch (port i) and data load (port d).
- Grants one requester at a time with round-robin fairness and drives the engine's level-held start/done handshake.
- Applies a per-transaction watchdog.
- Converts the engine's MSB-first byte stream into little-endian RV32E data.
- Sits between the core's fetch/LSU units and the SPI read engine.

Parameters:
- TIMEOUT_CYCLES, 4096: cycles a granted transaction may hold mem_start high before it is aborted.
- TMO_W, 16: width of the watchdog counter; must satisfy 2^TMO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- i_req  in  1  instruction read request; level, held until i_ack
- i_addr  in  24  instruction byte address
- i_nbytes  in  3  bytes to read; valid range 1..4
- i_ack  out  1  one-cycle completion pulse
- i_err  out  1  qualifies i_ack; 1 = timeout or illegal nbytes
- i_rdata  out  32  little-endian result; held until the next i_ack
- d_req, d_addr, d_nbytes, d_ack, d_err, d_rdata: same as port i, for data reads
- mem_start  out  1  engine start; held high until mem_done
- mem_addr  out  24  engine address; stable while mem_start=1
- mem_nbytes  out  4  engine read_bytes; stable while mem_start=1
- mem_done  in  1  engine completion; high while the engine is in its done state
- mem_rdata  in  32  engine result; valid when mem_done=1
- busy  out  1  state != IDLE

Behaviour:
- All outputs are registered.
- Reset values: mem_start=0, mem_addr=0, mem_nbytes=0, acks=0, errs=0, rdata=0, busy=0, state=IDLE, last_grant=d (so port i wins the first tie).
- Reset mid-transaction drops mem_start at the reset edge; no ack is issued for the aborted transaction.

State machine:
- IDLE:
  - Neither req: stay in IDLE.
  - One req: grant it.
  - Both reqs: grant the port that is not last_grant.
  - On grant: latch addr and nbytes into mem_addr/mem_nbytes, update last_grant, clear the watchdog.
  - nbytes legal (1..4): go to ISSUE, with mem_start=1 in the following cycle.
  - nbytes illegal (0, 5..7): go straight to RELEASE with err=1, rdata=0, no SPI traffic.
- ISSUE:
  - mem_start=1; watchdog increments each cycle.
  - mem_done=1: capture byte-swapped mem_rdata into the granted port's rdata, err=0, drop mem_start, go to RELEASE.
  - Else if watchdog reaches TIMEOUT_CYCLES-1: drop mem_start, rdata=0, err=1, go to RELEASE.
  - mem_done wins if it coincides with the timeout.
- RELEASE (exactly 1 cycle):
  - Granted port's ack=1 with err valid; mem_start=0.
  - Next state is always IDLE. Requests are ignored here, which guarantees mem_start is low for ≥2 cycles between transactions so the engine returns to its start state.
- Requester rule: drop req on the edge ending its ack cycle. A req still high in IDLE is a new request.
- Ungranted port: its req, addr and nbytes may change freely; its outputs are untouched.

Latency:
- req seen in IDLE at edge 0 → mem_start high in cycle 1.
- mem_done in cycle n → ack in cycle n+1.

Byte order (n = nbytes):
- The engine delivers byte b0 first, so b_k sits in mem_rdata[8(n-k)-1 -: 8].
- Output: rdata[8k+7:8k] = b_k for k < n; bytes at k ≥ n are zero.
- mem_rdata bits above 8n are ignored.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, ISSUE, RELEASE}
  - port-id constants PORT_I, PORT_D
  - NBYTES_MIN=1, NBYTES_MAX=4
- Sub-module mem_byte_order: combinational; inputs mem_rdata and nbytes, output is the swapped, zero-filled 32-bit word. Unit-testable on its own.

Test Plan:
- i_req, i_addr=0x000100, nbytes=4; engine model returns 0x11223344 → mem_addr=0x000100, mem_nbytes=4, mem_start high cycle 1; i_ack one cycle with i_rdata=0x44332211, i_err=0; d_ack stays 0.
- d_req, nbytes=2, mem_rdata=0x0000AABB → d_rdata=0x0000BBAA. Repeat with nbytes=1, mem_rdata=0xFFFFFFCC → d_rdata=0x000000CC.
- i_req and d_req rise in the same cycle, each re-requested immediately after its ack, for 4 transactions → grant order i, d, i, d; mem_start low ≥2 cycles between grants.
- d_req with mem_done never asserted, TIMEOUT_CYCLES=16 → mem_start falls after 16 high cycles; d_ack=1, d_err=1, d_rdata=0; next request is served normally.
- i_nbytes=0, then i_nbytes=5 → i_ack with i_err=1 within 2 cycles; mem_start never rises.
- rst_n low during ISSUE → mem_start=0 after that edge, no ack; after release, a pending req is granted to port i first.
